// File: rtl/amt_repair_if.sv
// Repair-path bus between the AMT repair sequencer, the AMT read ports and the rename map table.
// The master modport is the sequencer side; the slave modport is the AMT/RMT side.
interface amt_repair_if #(
    parameter int N_PACKETS = 8,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 7
);
    logic                                recoverFlag_i;
    logic [N_PACKETS-1:0][INDEX-1:0]     amtAddr_o;
    logic [N_PACKETS-1:0][WIDTH-1:0]     amtData_i;
    logic                                repairFlag_o;
    logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_o;
    logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_o;
    logic                                busy_o;
    logic                                done_o;

    modport master (
        input  recoverFlag_i, amtData_i,
        output amtAddr_o, repairFlag_o, repairAddr_o, repairData_o, busy_o, done_o
    );

    modport slave (
        output recoverFlag_i, amtData_i,
        input  amtAddr_o, repairFlag_o, repairAddr_o, repairData_o, busy_o, done_o
    );
endinterface

// File: rtl/amt_repair_sequencer.sv
// Walks the AMT N_PACKETS entries per cycle and replays them into the rename map table after a recovery.
// Optional feature macro: AMT_REPAIR_PERF_EN adds a saturating busy-cycle counter on repairCycles_o.
module amt_repair_sequencer #(
    parameter int N_ARCH_REGS = 34,
    parameter int N_PACKETS   = 8,
    parameter int INDEX       = 6,
    parameter int WIDTH       = 7
) (
    input  logic               clk,
    input  logic               reset,
`ifdef AMT_REPAIR_PERF_EN
    output logic [31:0]        repairCycles_o,
`endif
    amt_repair_if.master       bus
);
    localparam int B  = (N_ARCH_REGS + N_PACKETS - 1) / N_PACKETS;
    localparam int BW = $clog2(B) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                          state_q;
    logic [BW-1:0]                   batch_q;
    logic                            repairFlag_q;
    logic [N_PACKETS-1:0][INDEX-1:0] repairAddr_q;
    logic [N_PACKETS-1:0][WIDTH-1:0] repairData_q;
    logic [N_PACKETS-1:0][INDEX-1:0] rd_addr;

    // Lanes past the last architected register re-read the last entry, so the rewrite is idempotent.
    generate
        for (genvar gi = 0; gi < N_PACKETS; gi++) begin : g_lane
            logic [31:0] lin;
            assign lin         = 32'(batch_q) * 32'(N_PACKETS) + 32'(gi);
            assign rd_addr[gi] = (lin >= 32'(N_ARCH_REGS)) ? INDEX'(N_ARCH_REGS - 1) : lin[INDEX-1:0];
        end
    endgenerate

    assign bus.amtAddr_o    = rd_addr;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.done_o       = (state_q == DRAIN);
    assign bus.repairFlag_o = repairFlag_q;
    assign bus.repairAddr_o = repairAddr_q;
    assign bus.repairData_o = repairData_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            batch_q      <= '0;
            repairFlag_q <= 1'b0;
            repairAddr_q <= '0;
            repairData_q <= '0;
        end else begin
            repairFlag_q <= (state_q == READ);
            case (state_q)
                IDLE: begin
                    if (bus.recoverFlag_i) begin
                        state_q <= READ;
                        batch_q <= '0;
                    end
                end
                READ: begin
                    repairAddr_q <= rd_addr;
                    repairData_q <= bus.amtData_i;
                    // A restart still lets the batch read this cycle go out; it is AMT data and harmless.
                    if (bus.recoverFlag_i) begin
                        batch_q <= '0;
                    end else if (batch_q == BW'(B - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        batch_q <= batch_q + BW'(1);
                    end
                end
                DRAIN: begin
                    batch_q <= '0;
                    state_q <= bus.recoverFlag_i ? READ : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    batch_q <= '0;
                end
            endcase
        end
    end

`ifdef AMT_REPAIR_PERF_EN
    logic [31:0] cycles_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else if ((state_q != IDLE) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
    assign repairCycles_o = cycles_q;
`endif
endmodule
